coin_total_counter: RTL and testbench
=====================================

COIN_TOTAL_COUNTER -- requirements
Module: coin_total_counter

Interface
REQ-001 SHALL have parameter PRICE, default 7, the vend price in units; the legal range is 1..7.
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, the number of clk cycles the result stays displayed after a vend or refund.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4, the stable-high cycles required when debounce is compiled in.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 coin1_btn  input  1  raw asynchronous push-button; adds 1 unit.
REQ-007 coin2_btn  input  1  raw asynchronous push-button; adds 2 units.
REQ-008 cancel_btn  input  1  raw asynchronous push-button; requests a refund.
REQ-009 total  output  4  accumulated units (0..9) that feed the downstream 7-segment total decoder.
REQ-010 change  output  4  units returned (0..9), held during HOLD.
REQ-011 dispense  output  1  one-cycle vend strobe.
REQ-012 busy  output  1  high while in VEND or HOLD.

Function
REQ-013 Each button SHALL pass through a two-flop synchronizer followed by a rising-edge detector that produces a one-cycle event pulse.
REQ-014 The FSM SHALL have exactly the states IDLE, COLLECT, VEND and HOLD.
REQ-015 Coin events in IDLE or COLLECT SHALL register total <= total + value at the edge following the event pulse, giving 3 clk edges from a raw rise to total updating when debounce is off.
REQ-016 Coin1 and coin2 events in the same cycle SHALL add 3.
REQ-017 IDLE SHALL move to COLLECT on any coin event whose sum is below PRICE.
REQ-018 When the new sum is at or above PRICE, from IDLE or COLLECT, the FSM SHALL go to VEND: total <= sum, change <= sum - PRICE.
REQ-019 The sum SHALL never exceed 9 because PRICE <= 7 and the maximum add is 3; the arithmetic SHALL use 4-bit unsigned values with no wrap.
REQ-020 VEND SHALL assert dispense for exactly one cycle and then go to HOLD.
REQ-021 HOLD SHALL keep total and change for HOLD_CYCLES cycles, then go to IDLE with total=0 and change=0.
REQ-022 A cancel event in COLLECT SHALL set change <= total and total <= 0, and go to HOLD with no dispense.
REQ-023 Cancel in IDLE SHALL be ignored.
REQ-024 Cancel and a coin event in the same cycle in COLLECT SHALL resolve in favour of cancel, and the coin SHALL be discarded.
REQ-025 Coin and cancel events in VEND or HOLD SHALL be ignored and SHALL NOT be queued.
REQ-026 A button held high SHALL produce exactly one event.

Reset
REQ-027 rst high SHALL immediately force state=IDLE, total=0, change=0, dispense=0, busy=0, clear the synchronizer, edge and debounce registers, and clear the hold counter.
REQ-028 Reset asserted mid-HOLD or mid-COLLECT SHALL discard the accumulated value with no dispense.
REQ-029 A button already high when rst releases SHALL NOT generate an event until it is released and pressed again.

Configuration
REQ-030 With macro COIN_DEBOUNCE_EN defined, each synchronized button SHALL be required to stay high DEBOUNCE_CYCLES consecutive cycles before its event pulse, with any low sample restarting the count.
REQ-031 Without COIN_DEBOUNCE_EN, the event SHALL fire on the first synchronized high, with no debounce counters in the design.

Structure
REQ-032 Package coin_pkg SHALL hold the state enum typedef (IDLE, COLLECT, VEND, HOLD), the constants COIN1_VALUE=1, COIN2_VALUE=2 and TOTAL_MAX=9, and the 4-bit unit typedef.
REQ-033 Sub-module btn_event SHALL contain the synchronizer, the optional debounce and the edge detect, and SHALL be instantiated three times.
REQ-034 total SHALL connect directly to the existing total decoder at the top level, outside this block.

Verification
REQ-035 Reset release, then coin1 pressed 3 times -> total 1, 2, 3, each update 3 edges after the raw rise; state COLLECT; dispense 0.
REQ-036 From total 5, coin2 -> total 7, change 0, dispense high 1 cycle, busy high; after 8 HOLD cycles -> total 0, busy 0.
REQ-037 From total 6, coin1 and coin2 in the same cycle -> total 9, change 2, one dispense pulse.
REQ-038 From total 4, cancel and coin2 in the same cycle -> total 0, change 4, no dispense, HOLD; coin presses during HOLD leave total at 0.
REQ-039 rst asserted mid-HOLD with change 3 -> all outputs 0 asynchronously, before the next clk edge.
REQ-040 With COIN_DEBOUNCE_EN, a coin1 glitch lasting 3 cycles -> no change; a 4-cycle press -> total +1; without the macro, a 1-cycle glitch -> total +1.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared types and constants for the coin total counter.
package coin_pkg;

  // Vending controller states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Money is counted in whole units, 0..9, in four unsigned bits.
  typedef logic [3:0] unit_t;

  localparam unit_t COIN1_VALUE = 4'd1;
  localparam unit_t COIN2_VALUE = 4'd2;
  localparam unit_t TOTAL_MAX   = 4'd9;

endpackage

// File: rtl/btn_event.sv
// Raw push-button to one-cycle event pulse: two-flop synchronizer, optional
// debounce (compiled in with COIN_DEBOUNCE_EN), then a rising-edge detector.
// The detector is only armed after a low level has been seen once reset has
// released, so a button held through reset never fires.
module btn_event
`ifdef COIN_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_evt
);

  logic [1:0] r_sync;
  logic [1:0] r_vld;
  logic       r_armed;
  logic       r_prev;
  logic       w_level;

`ifdef COIN_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [DB_W-1:0] r_db_cnt;

  // Count consecutive high samples; any low sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt <= '0;
    end else if (!r_sync[1]) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt != DB_LAST) begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  assign w_level = r_sync[1] && (r_db_cnt == DB_LAST);
`else
  assign w_level = r_sync[1];
`endif

  // Synchronize the raw button and track when the synchronizer holds real data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_vld   <= '0;
      r_armed <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      r_vld  <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_sync[1]) begin
        r_armed <= 1'b1;
      end
      r_prev <= w_level;
    end
  end

  assign o_evt = w_level && !r_prev && r_armed;

endmodule

// File: rtl/coin_total_counter.sv
// Coin accumulator with vend/refund FSM (IDLE, COLLECT, VEND, HOLD).
// Define COIN_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable-high cycles on
// each button before its event fires; without it events fire on the first
// synchronized high. total feeds the 7-segment total decoder outside this block.
module coin_total_counter
  import coin_pkg::*;
#(
  parameter int PRICE           = 7,
  parameter int HOLD_CYCLES     = 8,
  parameter int DEBOUNCE_CYCLES = 4
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       coin1_btn,
  input  logic       coin2_btn,
  input  logic       cancel_btn,
  output logic [3:0] total,
  output logic [3:0] change,
  output logic       dispense,
  output logic       busy
);

  if (PRICE < 1 || PRICE > 7) begin : g_bad_price
    $error("coin_total_counter: PRICE must be 1..7");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("coin_total_counter: HOLD_CYCLES must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("coin_total_counter: DEBOUNCE_CYCLES must be at least 1");
  end

  localparam unit_t PRICE_U = unit_t'(PRICE);
  localparam int    HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  // Unsigned add that clamps at TOTAL_MAX instead of wrapping.
  function automatic unit_t sat_add(input unit_t a, input unit_t b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, TOTAL_MAX}) begin
      return TOTAL_MAX;
    end
    return s[3:0];
  endfunction

  state_t            r_state;
  unit_t             r_total;
  unit_t             r_change;
  logic [HOLD_W-1:0] r_hold_cnt;

  state_t            w_state_nxt;
  unit_t             w_total_nxt;
  unit_t             w_change_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;

  logic  w_evt_c1;
  logic  w_evt_c2;
  logic  w_evt_cn;
  logic  w_coin;
  unit_t w_add;
  unit_t w_sum;
  logic  w_reach;

  btn_event
`ifdef COIN_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_coin1 (.clk(clk), .rst(rst), .i_btn(coin1_btn), .o_evt(w_evt_c1));

  btn_event
`ifdef COIN_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_coin2 (.clk(clk), .rst(rst), .i_btn(coin2_btn), .o_evt(w_evt_c2));

  btn_event
`ifdef COIN_DEBOUNCE_EN
    #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
    u_cancel (.clk(clk), .rst(rst), .i_btn(cancel_btn), .o_evt(w_evt_cn));

  assign w_coin  = w_evt_c1 || w_evt_c2;
  assign w_add   = (w_evt_c1 ? COIN1_VALUE : 4'd0) + (w_evt_c2 ? COIN2_VALUE : 4'd0);
  assign w_sum   = sat_add(r_total, w_add);
  assign w_reach = (w_sum >= PRICE_U);

  // State, money and hold-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_total    <= '0;
      r_change   <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_total    <= w_total_nxt;
      r_change   <= w_change_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  // Next-state logic; cancel outranks a coin in COLLECT, and events
  // arriving in VEND or HOLD are dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_total_nxt  = r_total;
    w_change_nxt = r_change;
    w_hold_nxt   = r_hold_cnt;
    unique case (r_state)
      IDLE, COLLECT: begin
        if (r_state == COLLECT && w_evt_cn) begin
          w_change_nxt = r_total;
          w_total_nxt  = '0;
          w_hold_nxt   = '0;
          w_state_nxt  = HOLD;
        end else if (w_coin) begin
          w_total_nxt = w_sum;
          if (w_reach) begin
            w_change_nxt = w_sum - PRICE_U;
            w_state_nxt  = VEND;
          end else begin
            w_state_nxt = COLLECT;
          end
        end
      end
      VEND: begin
        w_hold_nxt  = '0;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_total_nxt  = '0;
          w_change_nxt = '0;
          w_hold_nxt   = '0;
          w_state_nxt  = IDLE;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign total    = r_total;
  assign change   = r_change;
  assign dispense = (r_state == VEND);
  assign busy     = (r_state == VEND) || (r_state == HOLD);

endmodule

// File: tb/tb_coin_total_counter.sv
// Scoreboard bench for coin_total_counter: each stimulus pushes the output
// snapshots it should cause (with the cycle they must appear); a negedge
// monitor pops one entry per observed output change and compares it.
`timescale 1ns/1ps
module tb_coin_total_counter;
  import coin_pkg::*;

  localparam int PRICE           = 7;
  localparam int HOLD_CYCLES     = 8;
  localparam int DEBOUNCE_CYCLES = 4;
`ifdef COIN_DEBOUNCE_EN
  localparam int LAT = 2 + DEBOUNCE_CYCLES;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       coin1_btn, coin2_btn, cancel_btn;
  logic [3:0] total, change;
  logic       dispense, busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    logic [3:0] total;
    logic [3:0] change;
    logic       disp;
    logic       busy;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [9:0] last_snap;
  logic [9:0] snap;
  bit         mon_en = 1'b0;
  int         t0;

  coin_total_counter #(
    .PRICE(PRICE),
    .HOLD_CYCLES(HOLD_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .coin1_btn(coin1_btn),
    .coin2_btn(coin2_btn),
    .cancel_btn(cancel_btn),
    .total(total),
    .change(change),
    .dispense(dispense),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_at(input int c, input int t, input int ch, input int d, input int b);
    exp_t e;
    e.cyc    = c;
    e.total  = 4'(t);
    e.change = 4'(ch);
    e.disp   = d[0];
    e.busy   = b[0];
    sb.push_back(e);
  endtask

  task automatic at_negedge(output int t);
    @(negedge clk);
    t = cyc;
  endtask

  // Drive buttons now, hold them for `hold` cycles, release, then idle `gap` cycles.
  task automatic drive(input logic b1, input logic b2, input logic bc, input int hold, input int gap);
    coin1_btn  = b1;
    coin2_btn  = b2;
    cancel_btn = bc;
    repeat (hold) @(negedge clk);
    coin1_btn  = 1'b0;
    coin2_btn  = 1'b0;
    cancel_btn = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Plain coin press that stays below the price.
  task automatic coin(input logic b1, input logic b2, input int exp_total);
    at_negedge(t0);
    expect_at(t0 + LAT, exp_total, 0, 0, 0);
    drive(b1, b2, 1'b0, 5, 4);
  endtask

  // Each output change seen at a negedge consumes one scoreboard entry.
  always @(negedge clk) begin
    if (mon_en) begin
      snap = {total, change, dispense, busy};
      if (snap !== last_snap) begin
        if (sb.size() == 0) begin
          chk("sb_pending", 0, 1);
        end else begin
          mon_e = sb.pop_front();
          chk("when",     cyc,         mon_e.cyc);
          chk("total",    int'(total), int'(mon_e.total));
          chk("change",   int'(change), int'(mon_e.change));
          chk("dispense", int'(dispense), int'(mon_e.disp));
          chk("busy",     int'(busy),  int'(mon_e.busy));
        end
        last_snap = snap;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    coin1_btn  = 1'b0;
    coin2_btn  = 1'b0;
    cancel_btn = 1'b0;
    idle(3);
    chk("rst_total",    int'(total),    0);
    chk("rst_change",   int'(change),   0);
    chk("rst_dispense", int'(dispense), 0);
    chk("rst_busy",     int'(busy),     0);
    rst = 1'b0;
    idle(5);
    last_snap = '0;
    mon_en    = 1'b1;

    // Three coin1 presses: 1, 2, 3, each LAT edges after the raw rise.
    for (int k = 1; k <= 3; k++) begin
      coin(1'b1, 1'b0, k);
    end
    chk("collect_state", int'(dut.r_state), int'(COLLECT));

    // 3 -> 5, then coin2 reaches exactly the price: vend, change 0.
    coin(1'b0, 1'b1, 5);
    at_negedge(t0);
    expect_at(t0 + LAT,                   7, 0, 1, 1);
    expect_at(t0 + LAT + 1,               7, 0, 0, 1);
    expect_at(t0 + LAT + 1 + HOLD_CYCLES, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 5, 4);
    idle(12);

    // 6 plus coin1 and coin2 together: 9, change 2.
    coin(1'b0, 1'b1, 2);
    coin(1'b0, 1'b1, 4);
    coin(1'b0, 1'b1, 6);
    at_negedge(t0);
    expect_at(t0 + LAT,                   9, 2, 1, 1);
    expect_at(t0 + LAT + 1,               9, 2, 0, 1);
    expect_at(t0 + LAT + 1 + HOLD_CYCLES, 0, 0, 0, 0);
    drive(1'b1, 1'b1, 1'b0, 5, 4);
    idle(12);

    // 4 with cancel and coin2 together: refund 4, coin discarded; coin in HOLD ignored.
    coin(1'b0, 1'b1, 2);
    coin(1'b0, 1'b1, 4);
    at_negedge(t0);
    expect_at(t0 + LAT,               0, 4, 0, 1);
    expect_at(t0 + LAT + HOLD_CYCLES, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 1'b1, 5, 0);
    drive(1'b1, 1'b0, 1'b0, 5, 4);
    idle(12);
    chk("hold_coin_total", int'(total), 0);

    // Cancel at 3, then asynchronous reset mid-HOLD.
    coin(1'b0, 1'b1, 2);
    coin(1'b1, 1'b0, 3);
    at_negedge(t0);
    expect_at(t0 + LAT, 0, 3, 0, 1);
    drive(1'b0, 1'b0, 1'b1, 5, 0);
    idle(2);
    chk("mid_hold_busy",   int'(busy),   1);
    chk("mid_hold_change", int'(change), 3);
    @(negedge clk);
    mon_en = 1'b0;
    coin1_btn = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_total",    int'(total),    0);
    chk("arst_change",   int'(change),   0);
    chk("arst_dispense", int'(dispense), 0);
    chk("arst_busy",     int'(busy),     0);

    // coin1 held across reset release must not count.
    @(negedge clk);
    rst       = 1'b0;
    last_snap = '0;
    mon_en    = 1'b1;
    idle(6);
    coin1_btn = 1'b0;
    idle(5);
    chk("held_thru_rst", int'(total), 0);
    coin(1'b1, 1'b0, 1);

`ifdef COIN_DEBOUNCE_EN
    // 3-cycle glitch is filtered, 4-cycle press counts.
    at_negedge(t0);
    drive(1'b1, 1'b0, 1'b0, 3, 4);
    idle(4);
    chk("glitch_total", int'(total), 1);
    at_negedge(t0);
    expect_at(t0 + LAT, 2, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 4, 4);
`else
    // A one-cycle glitch counts without debounce.
    at_negedge(t0);
    expect_at(t0 + LAT, 2, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1, 4);
`endif
    idle(4);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
